// File: rtl/vending_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vending_pkg
// Purpose  : Shared state encoding and saturating-add helper for the vending
//            change controller.
// Revision : 1.0 - initial release
// ============================================================================
package vending_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE     = 3'd0;
    localparam state_t COLLECT  = 3'd1;
    localparam state_t VEND     = 3'd2;
    localparam state_t DISPENSE = 3'd3;
    localparam state_t REFUND   = 3'd4;

    // a + b clamped to max_val; callers cast the result down to their width
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max_val}) ? max_val : s[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : change_dispenser
// Purpose  : Loadable owed down-counter that hands out one unit per
//            chg_valid/chg_ready beat, tagged as change or refund.
// Revision : 1.0 - initial release
// ============================================================================
module change_dispenser #(
    parameter int OW = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [OW-1:0] load_val,
    input  logic          load_refund,
    input  logic          en,
    input  logic          chg_ready,
    output logic          chg_valid,
    output logic          chg_is_refund,
    output logic          beat,
    output logic          owed_zero,
    output logic          done
);

    localparam logic [OW-1:0] C_ONE = {{(OW-1){1'b0}}, 1'b1};

    logic [OW-1:0] owed_q, owed_d;
    logic          refund_q, refund_d;

    assign owed_zero     = (owed_q == '0);
    assign chg_valid     = en & ~owed_zero;
    assign beat          = chg_valid & chg_ready;
    assign chg_is_refund = chg_valid & refund_q;
    // done covers both an empty load and the final unit leaving this cycle
    assign done          = owed_zero | (beat & (owed_q == C_ONE));

    // next owed count: a load overrides, otherwise each beat takes one unit
    always_comb begin
        owed_d   = owed_q;
        refund_d = refund_q;
        if (load) begin
            owed_d   = load_val;
            refund_d = load_refund;
        end else if (beat) begin
            owed_d = owed_q - C_ONE;
        end
    end

    // owed counter and refund tag registers
    always_ff @(posedge clock) begin
        if (reset) begin
            owed_q   <= '0;
            refund_q <= 1'b0;
        end else begin
            owed_q   <= owed_d;
            refund_q <= refund_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vending_change_controller.sv
`default_nettype none
// ============================================================================
// Module   : vending_change_controller
// Purpose  : Runs a vending transaction: latches cost, accumulates coins,
//            decides vend/refund, dispenses change from a finite inventory.
//            Optional macro VEND_COUNT_EN adds a 16-bit wrapping vend counter.
// Revision : 1.0 - initial release
// ============================================================================
module vending_change_controller
    import vending_pkg::*;
#(
    parameter int W        = 4,
    parameter int INV_W    = 4,
    parameter int INV_INIT = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [W-1:0]     cost,
    input  logic             coin_valid,
    input  logic [W-1:0]     coin_val,
    output logic             coin_ready,
    input  logic             cancel,
    input  logic             exact_only,
    input  logic             restock_valid,
    input  logic [INV_W-1:0] restock_amt,
    output logic             chg_valid,
    input  logic             chg_ready,
    output logic             chg_is_refund,
    output logic             vend,
    output logic             exact_amount,
    output logic             not_enough_chg,
    output logic [INV_W-1:0] remaining,
    output logic [W:0]       paid_total,
    output logic             busy
`ifdef VEND_COUNT_EN
    ,
    output logic [15:0]      vend_count
`endif
);

    localparam logic [31:0] C_PAID_MAX = (32'd1 << (W + 1)) - 32'd1;
    localparam logic [31:0] C_INV_MAX  = (32'd1 << INV_W) - 32'd1;

    state_t           state_q, state_d;
    logic [W-1:0]     cost_q, cost_d;
    logic [W:0]       paid_q, paid_d;
    logic             exact_q, exact_d;
    logic             nec_q, nec_d;
    logic [INV_W-1:0] remaining_q, remaining_d;

    logic [W:0]       w_cost_ext, w_diff, w_paid_plus, w_load_val;
    logic [INV_W-1:0] w_rem_base;
    logic             w_coin_fire, w_load, w_load_refund;
    logic             w_beat, w_owed_zero, w_done, w_disp_en, w_dec;

    assign w_cost_ext  = {1'b0, cost_q};
    assign w_diff      = paid_q - w_cost_ext;
    assign coin_ready  = (state_q == COLLECT) && (paid_q < w_cost_ext);
    assign w_coin_fire = coin_valid & coin_ready;
    assign w_paid_plus = (W + 1)'(sat_add(32'(paid_q), 32'(coin_val), C_PAID_MAX));
    assign w_disp_en   = (state_q == DISPENSE) || (state_q == REFUND);
    // only real change draws on the inventory; refunds come from escrow
    assign w_dec       = w_beat & (state_q == DISPENSE);

    assign vend           = (state_q == VEND);
    assign busy           = (state_q != IDLE);
    assign exact_amount   = exact_q;
    assign not_enough_chg = nec_q;
    assign remaining      = remaining_q;
    assign paid_total     = paid_q;

    change_dispenser #(.OW(W + 1)) u_disp (
        .clock         (clock),
        .reset         (reset),
        .load          (w_load),
        .load_val      (w_load_val),
        .load_refund   (w_load_refund),
        .en            (w_disp_en),
        .chg_ready     (chg_ready),
        .chg_valid     (chg_valid),
        .chg_is_refund (chg_is_refund),
        .beat          (w_beat),
        .owed_zero     (w_owed_zero),
        .done          (w_done)
    );

    // transaction FSM: collection, vend/refund decision, dispenser loading
    always_comb begin
        state_d       = state_q;
        cost_d        = cost_q;
        paid_d        = paid_q;
        exact_d       = exact_q;
        nec_d         = nec_q;
        w_load        = 1'b0;
        w_load_val    = paid_q;
        w_load_refund = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COLLECT;
                    cost_d  = cost;
                    paid_d  = '0;
                    exact_d = 1'b0;
                    nec_d   = 1'b0;
                end
            end
            COLLECT: begin
                if (cancel) begin
                    // a coin taken in the same cycle goes back with the escrow
                    w_load        = 1'b1;
                    w_load_refund = 1'b1;
                    w_load_val    = w_coin_fire ? w_paid_plus : paid_q;
                    paid_d        = w_load_val;
                    state_d       = REFUND;
                end else if (w_coin_fire) begin
                    paid_d = w_paid_plus;
                end else if (paid_q >= w_cost_ext) begin
                    w_load = 1'b1;
                    if (w_diff == '0) begin
                        exact_d    = 1'b1;
                        w_load_val = '0;
                        state_d    = VEND;
                    end else if (exact_only) begin
                        w_load_refund = 1'b1;
                        state_d       = REFUND;
                    end else if (32'(w_diff) > 32'(remaining_q)) begin
                        nec_d         = 1'b1;
                        w_load_refund = 1'b1;
                        state_d       = REFUND;
                    end else begin
                        w_load_val = w_diff;
                        state_d    = VEND;
                    end
                end
            end
            VEND:     state_d = w_owed_zero ? IDLE : DISPENSE;
            DISPENSE: if (w_done) state_d = IDLE;
            REFUND:   if (w_done) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // inventory: take the dispensed unit first, then add a saturating restock
    always_comb begin
        w_rem_base  = remaining_q - {{(INV_W-1){1'b0}}, w_dec};
        remaining_d = w_rem_base;
        if (restock_valid) begin
            remaining_d = INV_W'(sat_add(32'(w_rem_base), 32'(restock_amt), C_INV_MAX));
        end
    end

    // state, transaction and inventory registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cost_q      <= '0;
            paid_q      <= '0;
            exact_q     <= 1'b0;
            nec_q       <= 1'b0;
            remaining_q <= INV_W'(INV_INIT);
        end else begin
            state_q     <= state_d;
            cost_q      <= cost_d;
            paid_q      <= paid_d;
            exact_q     <= exact_d;
            nec_q       <= nec_d;
            remaining_q <= remaining_d;
        end
    end

`ifdef VEND_COUNT_EN
    logic [15:0] vend_count_q, vend_count_d;

    assign vend_count = vend_count_q;

    // next vend count, wrapping naturally at 16 bits
    always_comb begin
        vend_count_d = vend_count_q + {15'd0, vend};
    end

    // vend counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            vend_count_q <= '0;
        end else begin
            vend_count_q <= vend_count_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vending_change_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_vending_change_controller
// Purpose  : Directed self-checking bench for vending_change_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vending_change_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  cost = '0;
    logic        coin_valid = 1'b0;
    logic [3:0]  coin_val = '0;
    logic        coin_ready;
    logic        cancel = 1'b0;
    logic        exact_only = 1'b0;
    logic        restock_valid = 1'b0;
    logic [3:0]  restock_amt = '0;
    logic        chg_valid;
    logic        chg_ready = 1'b0;
    logic        chg_is_refund;
    logic        vend;
    logic        exact_amount;
    logic        not_enough_chg;
    logic [3:0]  remaining;
    logic [4:0]  paid_total;
    logic        busy;
`ifdef VEND_COUNT_EN
    logic [15:0] vend_count;
`endif

    int n_checks    = 0;
    int n_errors    = 0;
    int vend_pulses = 0;
    int v0;
    int beats;

    always #5 clock = ~clock;

    vending_change_controller dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .cost           (cost),
        .coin_valid     (coin_valid),
        .coin_val       (coin_val),
        .coin_ready     (coin_ready),
        .cancel         (cancel),
        .exact_only     (exact_only),
        .restock_valid  (restock_valid),
        .restock_amt    (restock_amt),
        .chg_valid      (chg_valid),
        .chg_ready      (chg_ready),
        .chg_is_refund  (chg_is_refund),
        .vend           (vend),
        .exact_amount   (exact_amount),
        .not_enough_chg (not_enough_chg),
        .remaining      (remaining),
        .paid_total     (paid_total),
        .busy           (busy)
`ifdef VEND_COUNT_EN
        ,
        .vend_count     (vend_count)
`endif
    );

    always @(negedge clock) begin
        if (vend === 1'b1) vend_pulses++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic start_txn(input logic [3:0] c);
        start = 1'b1;
        cost  = c;
        tick();
        start = 1'b0;
    endtask

    task automatic insert_coin(input logic [3:0] v);
        check_eq("coin_ready", 32'(coin_ready), 1);
        coin_valid = 1'b1;
        coin_val   = v;
        tick();
        coin_valid = 1'b0;
    endtask

    // runs the change/refund handshake to completion, optionally toggling
    // ready and injecting a restock of 3 on the first accepted beat
    task automatic drain(input logic exp_refund, input bit toggle,
                         input bit restock_first, output int n);
        int  cyc = 0;
        bit  restocked = 1'b0;
        n = 0;
        while (busy && cyc < 200) begin
            chg_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            if (restock_first && chg_ready && chg_valid && !restocked) begin
                restock_valid = 1'b1;
                restock_amt   = 4'd3;
                restocked     = 1'b1;
            end
            if (chg_valid && chg_ready) begin
                n++;
                check_eq("beat_refund_tag", 32'(chg_is_refund), 32'(exp_refund));
            end
            tick();
            restock_valid = 1'b0;
            cyc++;
        end
        chg_ready = 1'b0;
        check_eq("drain_idle", 32'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_remaining", 32'(remaining), 8);
        check_eq("rst_paid", 32'(paid_total), 0);
        check_eq("rst_chg_valid", 32'(chg_valid), 0);
        check_eq("rst_vend", 32'(vend), 0);
        check_eq("rst_coin_ready", 32'(coin_ready), 0);
        check_eq("rst_flags", 32'({exact_amount, not_enough_chg}), 0);
`ifdef VEND_COUNT_EN
        check_eq("rst_vend_count", 32'(vend_count), 0);
`endif

        // 1: exact payment
        v0 = vend_pulses;
        start_txn(4'd5);
        check_eq("t1_busy", 32'(busy), 1);
        insert_coin(4'd3);
        insert_coin(4'd2);
        check_eq("t1_paid", 32'(paid_total), 5);
        check_eq("t1_coin_ready_full", 32'(coin_ready), 0);
        tick();
        check_eq("t1_vend", 32'(vend), 1);
        check_eq("t1_exact", 32'(exact_amount), 1);
        tick();
        check_eq("t1_vend_off", 32'(vend), 0);
        check_eq("t1_idle", 32'(busy), 0);
        check_eq("t1_no_chg", 32'(chg_valid), 0);
        check_eq("t1_remaining", 32'(remaining), 8);
        check_eq("t1_pulses", 32'(vend_pulses - v0), 1);

        // 2: change of 4
        v0 = vend_pulses;
        start_txn(4'd3);
        insert_coin(4'd7);
        tick();
        check_eq("t2_vend", 32'(vend), 1);
        check_eq("t2_chg_during_vend", 32'(chg_valid), 0);
        tick();
        check_eq("t2_chg_valid", 32'(chg_valid), 1);
        drain(1'b0, 1'b0, 1'b0, beats);
        check_eq("t2_beats", 32'(beats), 4);
        check_eq("t2_remaining", 32'(remaining), 4);
        check_eq("t2_pulses", 32'(vend_pulses - v0), 1);

        // 3: not enough change, whole escrow refunded
        do_reset();
        v0 = vend_pulses;
        start_txn(4'd3);
        insert_coin(4'd15);
        tick();
        check_eq("t3_nec", 32'(not_enough_chg), 1);
        check_eq("t3_refund_tag", 32'(chg_is_refund), 1);
        drain(1'b1, 1'b0, 1'b0, beats);
        check_eq("t3_beats", 32'(beats), 15);
        check_eq("t3_remaining", 32'(remaining), 8);
        check_eq("t3_pulses", 32'(vend_pulses - v0), 0);
        check_eq("t3_nec_sticky", 32'(not_enough_chg), 1);

        // 4: cancel with a concurrent coin
        v0 = vend_pulses;
        start_txn(4'd9);
        check_eq("t4_nec_cleared", 32'(not_enough_chg), 0);
        insert_coin(4'd4);
        check_eq("t4_coin_ready", 32'(coin_ready), 1);
        coin_valid = 1'b1;
        coin_val   = 4'd2;
        cancel     = 1'b1;
        tick();
        coin_valid = 1'b0;
        cancel     = 1'b0;
        check_eq("t4_paid", 32'(paid_total), 6);
        drain(1'b1, 1'b0, 1'b0, beats);
        check_eq("t4_beats", 32'(beats), 6);
        check_eq("t4_pulses", 32'(vend_pulses - v0), 0);
        check_eq("t4_remaining", 32'(remaining), 8);

        // 5a: exact-only mode refunds an overpayment
        v0 = vend_pulses;
        exact_only = 1'b1;
        start_txn(4'd1);
        insert_coin(4'd5);
        tick();
        exact_only = 1'b0;
        check_eq("t5a_vend", 32'(vend), 0);
        drain(1'b1, 1'b0, 1'b0, beats);
        check_eq("t5a_beats", 32'(beats), 5);
        check_eq("t5a_pulses", 32'(vend_pulses - v0), 0);

        // zero cost: decision in the first collect cycle
        start_txn(4'd0);
        tick();
        check_eq("c0_vend", 32'(vend), 1);
        check_eq("c0_exact", 32'(exact_amount), 1);
        tick();
        check_eq("c0_idle", 32'(busy), 0);

        // 5b: saturating restock, then toggled ready with a restock on a beat
        restock_valid = 1'b1;
        restock_amt   = 4'd15;
        tick();
        restock_valid = 1'b0;
        check_eq("t5b_restock_sat", 32'(remaining), 15);
        start_txn(4'd1);
        insert_coin(4'd5);
        tick();
        tick();
        drain(1'b0, 1'b1, 1'b1, beats);
        check_eq("t5b_beats", 32'(beats), 4);
        check_eq("t5b_remaining", 32'(remaining), 12);

        // 6: reset mid-dispense
        start_txn(4'd1);
        insert_coin(4'd5);
        tick();
        tick();
        chg_ready = 1'b1;
        tick();
        chg_ready = 1'b0;
        check_eq("t6_remaining_mid", 32'(remaining), 11);
        check_eq("t6_hold_valid", 32'(chg_valid), 1);
`ifdef VEND_COUNT_EN
        check_eq("t6_vend_count", 32'(vend_count), 3);
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("t6_idle", 32'(busy), 0);
        check_eq("t6_chg_valid", 32'(chg_valid), 0);
        check_eq("t6_remaining", 32'(remaining), 8);
        check_eq("t6_paid", 32'(paid_total), 0);
`ifdef VEND_COUNT_EN
        check_eq("t6_vend_count_rst", 32'(vend_count), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
